// File: rtl/pwconv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pwconv_pkg
//  Desc     : Shared types and constants for the pointwise 1x1 conv array.
//  Revision : 1.0 - initial release
// ============================================================================
package pwconv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    localparam int C_DEF_ACC_W  = 32;
    localparam int C_DEF_DATA_W = 8;
    localparam int C_INT8_MAX   = 127;
    localparam int C_INT8_MIN   = -128;

    function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
        return (num + den - 1) / den;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwconv_mac_lane.sv
`default_nettype none
// ============================================================================
//  Module   : pwconv_mac_lane
//  Desc     : One output channel: masked multipliers, S1 product registers,
//             adder tree and wrapping accumulator.
//  Revision : 1.0 - initial release
// ============================================================================
module pwconv_mac_lane
    import pwconv_pkg::*;
#(
    parameter int NUM_MACS = 16,
    parameter int DATA_W   = C_DEF_DATA_W,
    parameter int ACC_W    = C_DEF_ACC_W
)(
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       acc_clr_i,
    input  logic                       in_valid_i,
    input  logic [NUM_MACS-1:0]        mask_i,
    input  logic [NUM_MACS*DATA_W-1:0] act_i,
    input  logic [NUM_MACS*DATA_W-1:0] wgt_i,
    output logic                       s1_valid_o,
    output logic [ACC_W-1:0]           acc_o
);

    localparam int PROD_W = 2 * DATA_W;

    logic signed [PROD_W-1:0] w_prod [NUM_MACS];
    logic signed [PROD_W-1:0] prod_q [NUM_MACS];
    logic                     s1_valid_q;
    logic        [ACC_W-1:0]  acc_q;
    logic        [ACC_W-1:0]  w_sum;

    always_comb begin
        for (int i = 0; i < NUM_MACS; i++) begin
            w_prod[i] = '0;
            if (mask_i[i]) begin
                w_prod[i] = PROD_W'($signed(act_i[i*DATA_W +: DATA_W]))
                          * PROD_W'($signed(wgt_i[i*DATA_W +: DATA_W]));
            end
        end
    end

    // Products are sign-extended before summing so the tree wraps at ACC_W.
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < NUM_MACS; i++) begin
            w_sum = w_sum + ACC_W'(prod_q[i]);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid_q <= 1'b0;
            acc_q      <= '0;
            for (int i = 0; i < NUM_MACS; i++) begin
                prod_q[i] <= '0;
            end
        end else begin
            s1_valid_q <= in_valid_i && !flush_i;
            if (in_valid_i) begin
                for (int i = 0; i < NUM_MACS; i++) begin
                    prod_q[i] <= w_prod[i];
                end
            end
            if (acc_clr_i) begin
                acc_q <= '0;
            end else if (s1_valid_q) begin
                acc_q <= acc_q + w_sum;
            end
        end
    end

    assign s1_valid_o = s1_valid_q;
    assign acc_o      = acc_q;

endmodule
`default_nettype wire

// File: rtl/pointwise_conv1x1_array.sv
`default_nettype none
// ============================================================================
//  Module   : pointwise_conv1x1_array
//  Desc     : NUM_LANES-wide pointwise convolution engine with hardware tail
//             masking. Optional requantised output under PWCONV_REQUANT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module pointwise_conv1x1_array
    import pwconv_pkg::*;
#(
    parameter int NUM_MACS  = 16,
    parameter int NUM_LANES = 4,
    parameter int DATA_W    = C_DEF_DATA_W,
    parameter int ACC_W     = C_DEF_ACC_W,
    parameter int CH_W      = 10
)(
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [CH_W-1:0]                      cfg_num_input_ch_i,
`ifdef PWCONV_REQUANT_EN
    input  logic [4:0]                           cfg_shift_i,
    output logic [NUM_LANES*8-1:0]               res_q_o,
`endif
    input  logic                                 start_i,
    input  logic                                 clear_i,
    output logic                                 busy_o,
    input  logic                                 act_valid_i,
    output logic                                 act_ready_o,
    input  logic [NUM_MACS*DATA_W-1:0]           act_data_i,
    input  logic [NUM_LANES*NUM_MACS*DATA_W-1:0] wgt_data_i,
    output logic                                 res_valid_o,
    input  logic                                 res_ready_i,
    output logic [NUM_LANES*ACC_W-1:0]           res_data_o
);

    localparam logic [CH_W-1:0] C_MACS_CH = CH_W'(NUM_MACS);

    state_t                       state_q, state_d;
    logic [CH_W-1:0]              batches_q, batches_d;
    logic [CH_W-1:0]              rem_q, rem_d;
    logic [NUM_LANES*ACC_W-1:0]   res_data_q;
    logic [NUM_LANES*ACC_W-1:0]   w_acc_all;
    logic [NUM_LANES-1:0]         w_s1_valid;
    logic [NUM_MACS-1:0]          w_mask;
    logic                         w_act_fire;
    logic                         w_acc_clr;
    logic                         w_load_res;
    logic                         w_zero_res;

    assign act_ready_o = (state_q == ST_RUN) && (batches_q != '0);
    assign w_act_fire  = act_valid_i && act_ready_o;
    assign busy_o      = (state_q != ST_IDLE);
    assign res_valid_o = (state_q == ST_OUT);
    assign res_data_o  = res_data_q;

    // rem_q holds N - b*NUM_MACS for the current beat b.
    always_comb begin
        for (int i = 0; i < NUM_MACS; i++) begin
            w_mask[i] = (CH_W'(i) < rem_q);
        end
    end

    always_comb begin
        state_d    = state_q;
        batches_d  = batches_q;
        rem_d      = rem_q;
        w_acc_clr  = 1'b0;
        w_load_res = 1'b0;
        w_zero_res = 1'b0;
        if (clear_i) begin
            state_d    = ST_IDLE;
            w_acc_clr  = 1'b1;
            w_zero_res = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        w_acc_clr = 1'b1;
                        batches_d = CH_W'(ceil_div(32'(cfg_num_input_ch_i), NUM_MACS));
                        rem_d     = cfg_num_input_ch_i;
                        if (cfg_num_input_ch_i == '0) begin
                            state_d    = ST_OUT;
                            w_zero_res = 1'b1;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_act_fire) begin
                        batches_d = batches_q - 1'b1;
                        rem_d     = (rem_q > C_MACS_CH) ? (rem_q - C_MACS_CH) : '0;
                        if (batches_q == CH_W'(1)) begin
                            state_d = ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_s1_valid == '0) begin
                        state_d    = ST_OUT;
                        w_load_res = 1'b1;
                    end
                end
                ST_OUT: begin
                    if (res_ready_i) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    generate
        for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
            pwconv_mac_lane #(
                .NUM_MACS (NUM_MACS),
                .DATA_W   (DATA_W),
                .ACC_W    (ACC_W)
            ) u_lane (
                .clk_i      (clk_i),
                .rst_i      (rst_i),
                .flush_i    (clear_i),
                .acc_clr_i  (w_acc_clr),
                .in_valid_i (w_act_fire && !clear_i),
                .mask_i     (w_mask),
                .act_i      (act_data_i),
                .wgt_i      (wgt_data_i[l*NUM_MACS*DATA_W +: NUM_MACS*DATA_W]),
                .s1_valid_o (w_s1_valid[l]),
                .acc_o      (w_acc_all[l*ACC_W +: ACC_W])
            );
        end
    endgenerate

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            batches_q  <= '0;
            rem_q      <= '0;
            res_data_q <= '0;
        end else begin
            state_q   <= state_d;
            batches_q <= batches_d;
            rem_q     <= rem_d;
            if (w_zero_res) begin
                res_data_q <= '0;
            end else if (w_load_res) begin
                res_data_q <= w_acc_all;
            end
        end
    end

`ifdef PWCONV_REQUANT_EN
    logic [4:0]             shift_q;
    logic [NUM_LANES*8-1:0] res_q_q;
    logic [NUM_LANES*8-1:0] w_rq_all;

    // Round-half-up then arithmetic shift, widened by one bit so the rounding add cannot overflow.
    function automatic logic [7:0] requant(input logic signed [ACC_W-1:0] acc, input logic [4:0] sh);
        logic signed [ACC_W:0] ext;
        logic signed [ACC_W:0] rnd;
        logic signed [ACC_W:0] shd;
        ext = (ACC_W+1)'(acc);
        rnd = (sh != 5'd0) ? ((ACC_W+1)'(1) << (sh - 5'd1)) : '0;
        shd = (ext + rnd) >>> sh;
        if (shd > (ACC_W+1)'(C_INT8_MAX)) begin
            return 8'(C_INT8_MAX);
        end else if (shd < (ACC_W+1)'(C_INT8_MIN)) begin
            return 8'(C_INT8_MIN);
        end
        return shd[7:0];
    endfunction

    always_comb begin
        w_rq_all = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            w_rq_all[l*8 +: 8] = requant(w_acc_all[l*ACC_W +: ACC_W], shift_q);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shift_q <= '0;
            res_q_q <= '0;
        end else begin
            if (state_q == ST_IDLE && start_i && !clear_i) begin
                shift_q <= cfg_shift_i;
            end
            if (w_zero_res) begin
                res_q_q <= '0;
            end else if (w_load_res) begin
                res_q_q <= w_rq_all;
            end
        end
    end

    assign res_q_o = res_q_q;
`endif

endmodule
`default_nettype wire
